// File: rtl/wb_timer_pkg.sv
// ============================================================================
// Module  : wb_timer_pkg
// Brief   : Register offsets and default base address for the machine timer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_timer_pkg;

  localparam logic [1:0] MTIME_LO    = 2'd0;
  localparam logic [1:0] MTIME_HI    = 2'd1;
  localparam logic [1:0] MTIMECMP_LO = 2'd2;
  localparam logic [1:0] MTIMECMP_HI = 2'd3;

  localparam logic [7:0] TIMER_BASE  = 8'hc0;

endpackage

`default_nettype wire

// File: rtl/wb_timer_chip_select.sv
// ============================================================================
// Module  : chip_select
// Brief   : Upper-address decode and single-cycle acknowledge generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module chip_select
  import wb_timer_pkg::*;
#(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] ADDR = WIDTH'(TIMER_BASE)
) (
  input  logic             wb_ck,
  input  logic             wb_rst,
  input  logic [WIDTH-1:0] addr,
  input  logic             wb_cyc,
  output logic             cyc,
  output logic             ack
);

  assign cyc = wb_cyc & (addr == ADDR);

  // ack toggles off after one cycle so a held request still yields single pulses
  always_ff @(posedge wb_ck) begin
    if (wb_rst) begin
      ack <= 1'b0;
    end else begin
      ack <= cyc & ~ack;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_timer.sv
// ============================================================================
// Module  : wb_timer
// Brief   : Memory-mapped 64-bit mtime/mtimecmp machine timer with level irq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] ADDR    = WIDTH'(TIMER_BASE),
  parameter logic [63:0]      INITIAL = 64'h0
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        ck_en,
  input  logic [31:0] wb_dbus_adr,
  input  logic [31:0] wb_dbus_dat,
  input  logic        wb_dbus_we,
  input  logic        wb_dbus_cyc,
  output logic        wb_dbus_ack,
  output logic [31:0] rdt,
  output logic        irq
);

  logic        w_cyc;
  logic [1:0]  w_sel;
  logic        w_wr_commit;
  logic        w_rd_commit;
  logic        w_unused;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [31:0] r_mtime_hi_shadow;

  chip_select #(
    .WIDTH (WIDTH),
    .ADDR  (ADDR)
  ) u_chip_select (
    .wb_ck  (wb_clk),
    .wb_rst (wb_rst),
    .addr   (wb_dbus_adr[31:32-WIDTH]),
    .wb_cyc (wb_dbus_cyc),
    .cyc    (w_cyc),
    .ack    (wb_dbus_ack)
  );

  assign w_sel       = wb_dbus_adr[3:2];
  assign w_wr_commit = w_cyc &  wb_dbus_we & wb_dbus_ack;
  assign w_rd_commit = w_cyc & ~wb_dbus_we & wb_dbus_ack;
  assign w_unused    = ^{wb_dbus_adr[31-WIDTH:4], wb_dbus_adr[1:0]};

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_mtime           <= INITIAL;
      r_mtimecmp        <= 64'h0;
      r_mtime_hi_shadow <= INITIAL[63:32];
      irq               <= 1'b0;
    end else begin
      if (ck_en) begin
        r_mtime <= r_mtime + 64'd1;
      end
      // Shadow the upper word with the same mtime sample the low-word read returns
      if (w_rd_commit && (w_sel == MTIME_LO)) begin
        r_mtime_hi_shadow <= r_mtime[63:32];
      end
      if (w_wr_commit && (w_sel == MTIMECMP_LO)) begin
        r_mtimecmp[31:0] <= wb_dbus_dat;
      end
      if (w_wr_commit && (w_sel == MTIMECMP_HI)) begin
        r_mtimecmp[63:32] <= wb_dbus_dat;
      end
      irq <= (r_mtime >= r_mtimecmp);
    end
  end

  always_comb begin
    rdt = 32'h0;
    if (w_cyc && !wb_dbus_we) begin
      case (w_sel)
        MTIME_LO:    rdt = r_mtime[31:0];
        MTIME_HI:    rdt = r_mtime_hi_shadow;
        MTIMECMP_LO: rdt = r_mtimecmp[31:0];
        MTIMECMP_HI: rdt = r_mtimecmp[63:32];
        default:     rdt = 32'h0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_timer.sv
// ============================================================================
// Module  : tb_wb_timer
// Brief   : Directed self-checking bench for the wb_timer machine timer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_timer;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        ck_en;
  logic [31:0] wb_dbus_adr;
  logic [31:0] wb_dbus_dat;
  logic        wb_dbus_we;
  logic        wb_dbus_cyc;
  logic        wb_dbus_ack;
  logic [31:0] rdt;
  logic        irq;

  int checks = 0;
  int errors = 0;

  wb_timer #(
    .WIDTH   (8),
    .ADDR    (8'hc0),
    .INITIAL (64'h12345678fffffff0)
  ) dut (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .ck_en       (ck_en),
    .wb_dbus_adr (wb_dbus_adr),
    .wb_dbus_dat (wb_dbus_dat),
    .wb_dbus_we  (wb_dbus_we),
    .wb_dbus_cyc (wb_dbus_cyc),
    .wb_dbus_ack (wb_dbus_ack),
    .rdt         (rdt),
    .irq         (irq)
  );

  always #5 wb_clk = ~wb_clk;

  function automatic logic [31:0] tadr(input logic [3:0] off);
    return {8'hc0, 20'h0, off};
  endfunction

  task automatic bus_wr(input logic [3:0] off, input logic [31:0] d);
    int n;
    @(negedge wb_clk);
    wb_dbus_adr = tadr(off);
    wb_dbus_dat = d;
    wb_dbus_we  = 1'b1;
    wb_dbus_cyc = 1'b1;
    n = 0;
    do begin
      @(posedge wb_clk); #1; n++;
    end while (!wb_dbus_ack && n < 8);
    checks++;
    if (wb_dbus_ack !== 1'b1) begin
      errors++;
      $display("FAIL bus_wr_ack off=%0h: ack=%b required 1", off, wb_dbus_ack);
    end
    @(posedge wb_clk); #1;
    wb_dbus_cyc = 1'b0;
    wb_dbus_we  = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] off, output logic [31:0] d);
    int n;
    @(negedge wb_clk);
    wb_dbus_adr = tadr(off);
    wb_dbus_we  = 1'b0;
    wb_dbus_cyc = 1'b1;
    n = 0;
    do begin
      @(posedge wb_clk); #1; n++;
    end while (!wb_dbus_ack && n < 8);
    checks++;
    if (wb_dbus_ack !== 1'b1) begin
      errors++;
      $display("FAIL bus_rd_ack off=%0h: ack=%b required 1", off, wb_dbus_ack);
    end
    d = rdt;
    @(posedge wb_clk); #1;
    wb_dbus_cyc = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge wb_clk);
    wb_rst = 1'b1;
    repeat (4) @(posedge wb_clk);
    @(negedge wb_clk);
    wb_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (4) @(posedge wb_clk);
    #1;
    checks++;
    if (wb_dbus_ack !== 1'b0 || irq !== 1'b0 || rdt !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b irq=%b rdt=%h required 0 0 0", wb_dbus_ack, irq, rdt);
    end
    @(negedge wb_clk);
    wb_rst = 1'b0;
    @(posedge wb_clk); #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_after_reset: irq=%b required 1", irq);
    end
    bus_rd(4'h0, d);
    checks++;
    if (d !== 32'hfffffff0) begin errors++; $display("FAIL reset_mtime_lo: got %h required fffffff0", d); end
    bus_rd(4'h4, d);
    checks++;
    if (d !== 32'h12345678) begin errors++; $display("FAIL reset_mtime_hi: got %h required 12345678", d); end
    bus_rd(4'h8, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_cmp_lo: got %h required 0", d); end
    bus_rd(4'hc, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_cmp_hi: got %h required 0", d); end
  endtask

  task automatic test_idle_rdt();
    @(negedge wb_clk);
    wb_dbus_adr = tadr(4'h0);
    wb_dbus_we  = 1'b0;
    wb_dbus_cyc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge wb_clk); #1;
      checks++;
      if (rdt !== 32'h0 || wb_dbus_ack !== 1'b0) begin
        errors++;
        $display("FAIL idle_rdt cycle %0d: rdt=%h ack=%b required 0 0", i, rdt, wb_dbus_ack);
      end
    end
    @(negedge wb_clk);
    wb_dbus_adr = 32'h40000000;
    wb_dbus_cyc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge wb_clk); #1;
      checks++;
      if (rdt !== 32'h0 || wb_dbus_ack !== 1'b0) begin
        errors++;
        $display("FAIL unselected cycle %0d: rdt=%h ack=%b required 0 0", i, rdt, wb_dbus_ack);
      end
    end
    @(negedge wb_clk);
    wb_dbus_adr = tadr(4'h0);
    wb_dbus_we  = 1'b1;
    #1;
    checks++;
    if (rdt !== 32'h0) begin
      errors++;
      $display("FAIL rdt_during_write: rdt=%h required 0", rdt);
    end
    @(negedge wb_clk);
    wb_dbus_cyc = 1'b0;
    wb_dbus_we  = 1'b0;
    repeat (2) @(posedge wb_clk);
  endtask

  task automatic test_cmp_rw();
    logic [31:0] d;
    bus_wr(4'h8, 32'h12341234);
    bus_wr(4'hc, 32'habcdabcd);
    bus_rd(4'h8, d);
    checks++;
    if (d !== 32'h12341234) begin errors++; $display("FAIL cmp_lo_rw: got %h required 12341234", d); end
    bus_rd(4'hc, d);
    checks++;
    if (d !== 32'habcdabcd) begin errors++; $display("FAIL cmp_hi_rw: got %h required abcdabcd", d); end
    bus_wr(4'h0, 32'hdeadbeef);
    bus_wr(4'h4, 32'hcafef00d);
    bus_rd(4'h0, d);
    checks++;
    if (d !== 32'hfffffff0) begin errors++; $display("FAIL mtime_lo_readonly: got %h required fffffff0", d); end
    bus_rd(4'h4, d);
    checks++;
    if (d !== 32'h12345678) begin errors++; $display("FAIL mtime_hi_readonly: got %h required 12345678", d); end
  endtask

  task automatic test_rollover();
    logic [31:0] d;
    do_reset();
    @(negedge wb_clk); ck_en = 1'b1;
    repeat (13) @(posedge wb_clk);
    @(negedge wb_clk); ck_en = 1'b0;
    bus_rd(4'h0, d);
    checks++;
    if (d !== 32'hfffffffd) begin errors++; $display("FAIL roll_lo: got %h required fffffffd", d); end
    @(negedge wb_clk); ck_en = 1'b1;
    repeat (20) @(posedge wb_clk);
    @(negedge wb_clk); ck_en = 1'b0;
    bus_rd(4'h4, d);
    checks++;
    if (d !== 32'h12345678) begin errors++; $display("FAIL roll_shadow_hi: got %h required 12345678", d); end
    bus_rd(4'h0, d);
    checks++;
    if (d !== 32'h00000011) begin errors++; $display("FAIL roll_fresh_lo: got %h required 00000011", d); end
    bus_rd(4'h4, d);
    checks++;
    if (d !== 32'h12345679) begin errors++; $display("FAIL roll_fresh_hi: got %h required 12345679", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    int k;
    do_reset();
    bus_rd(4'h0, d);
    checks++;
    if (d !== 32'hfffffff0) begin errors++; $display("FAIL rst2_lo: got %h required fffffff0", d); end
    bus_rd(4'h4, d);
    checks++;
    if (d !== 32'h12345678) begin errors++; $display("FAIL rst2_hi: got %h required 12345678", d); end
    bus_wr(4'hc, 32'h12345679);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_latency: irq=%b required 1", irq); end
    @(posedge wb_clk); #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: irq=%b required 0", irq); end
    @(negedge wb_clk); ck_en = 1'b1;
    k = 0;
    do begin
      @(posedge wb_clk); #1; k++;
    end while (!irq && k < 40);
    @(negedge wb_clk); ck_en = 1'b0;
    checks++;
    if (irq !== 1'b1 || k != 17) begin
      errors++;
      $display("FAIL irq_rollover: irq=%b after %0d clocks required 1 after 17", irq, k);
    end
    bus_rd(4'h0, d);
    checks++;
    if (d !== 32'h00000001) begin errors++; $display("FAIL irq_mtime_lo: got %h required 00000001", d); end
    bus_rd(4'h4, d);
    checks++;
    if (d !== 32'h12345679) begin errors++; $display("FAIL irq_mtime_hi: got %h required 12345679", d); end
    bus_wr(4'h8, 32'hffff0000);
    @(posedge wb_clk); #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_raise_cmp: irq=%b required 0", irq); end
  endtask

  task automatic test_freeze_ack();
    logic [31:0] d;
    int acks;
    int doubles;
    logic prev;
    bus_rd(4'h0, d);
    checks++;
    if (d !== 32'h00000001) begin errors++; $display("FAIL frozen_lo_a: got %h required 00000001", d); end
    repeat (5) @(posedge wb_clk);
    bus_rd(4'h0, d);
    checks++;
    if (d !== 32'h00000001) begin errors++; $display("FAIL frozen_lo_b: got %h required 00000001", d); end
    @(negedge wb_clk);
    wb_dbus_adr = tadr(4'h8);
    wb_dbus_we  = 1'b0;
    wb_dbus_cyc = 1'b1;
    acks = 0; doubles = 0; prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge wb_clk); #1;
      if (wb_dbus_ack) acks++;
      if (wb_dbus_ack && prev) doubles++;
      prev = wb_dbus_ack;
    end
    @(negedge wb_clk); wb_dbus_cyc = 1'b0;
    checks++;
    if (acks != 3 || doubles != 0) begin
      errors++;
      $display("FAIL ack_pulse: acks=%0d doubles=%0d required 3 0", acks, doubles);
    end
    @(posedge wb_clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    @(negedge wb_clk);
    wb_dbus_adr = tadr(4'hc);
    wb_dbus_dat = 32'habcdabcd;
    wb_dbus_we  = 1'b1;
    wb_dbus_cyc = 1'b1;
    @(posedge wb_clk); #1;
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;
    checks++;
    if (wb_dbus_ack !== 1'b0) begin errors++; $display("FAIL mid_reset_ack: ack=%b required 0", wb_dbus_ack); end
    wb_dbus_cyc = 1'b0;
    wb_dbus_we  = 1'b0;
    repeat (3) @(posedge wb_clk);
    @(negedge wb_clk); wb_rst = 1'b0;
    bus_rd(4'hc, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_cmp_hi: got %h required 0", d); end
    bus_rd(4'h0, d);
    checks++;
    if (d !== 32'hfffffff0) begin errors++; $display("FAIL mid_reset_lo: got %h required fffffff0", d); end
  endtask

  initial begin
    wb_rst      = 1'b1;
    ck_en       = 1'b0;
    wb_dbus_adr = 32'h0;
    wb_dbus_dat = 32'h0;
    wb_dbus_we  = 1'b0;
    wb_dbus_cyc = 1'b0;
    test_reset();
    test_idle_rdt();
    test_cmp_rw();
    test_rollover();
    test_irq();
    test_freeze_ack();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
